// File: rtl/cen_gen_multi.sv
// -----------------------------------------------------------------------------
// cen_gen_multi
//
// Multi-channel fractional clock-enable generator. Each channel runs a
// num/den phase accumulator and emits a registered one-cycle enable pulse
// (ce) at an average rate of num/den of clk_sys. It also emits a square wave
// (tog) that inverts on every pulse.
//
// Ports
//   clk_sys  in   sole clock
//   reset    in   asynchronous active-high reset; loads INIT_NUM/INIT_DEN
//   pause    in   hold accumulators and tog, suppress ce
//   resync   in   zero every accumulator (phase alignment), suppress ce
//   wr       in   one-cycle configuration write strobe
//   wr_ch    in   channel index for the write (indices >= NCH are ignored)
//   wr_num   in   new numerator
//   wr_den   in   new denominator
//   rd_ch    in   readback channel index
//   rd_num   out  numerator of rd_ch (combinational, 0 if out of range)
//   rd_den   out  denominator of rd_ch (combinational, 0 if out of range)
//   ce       out  registered enable pulse, one bit per channel
//   tog      out  registered square wave, one bit per channel
// -----------------------------------------------------------------------------
module cen_gen_multi #(
    parameter int NCH      = 3,
    parameter int W        = 16,
    parameter int INIT_NUM = 1,
    parameter int INIT_DEN = 10
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           pause,
    input  logic           resync,
    input  logic           wr,
    input  logic [2:0]     wr_ch,
    input  logic [W-1:0]   wr_num,
    input  logic [W-1:0]   wr_den,
    input  logic [2:0]     rd_ch,
    output logic [W-1:0]   rd_num,
    output logic [W-1:0]   rd_den,
    output logic [NCH-1:0] ce,
    output logic [NCH-1:0] tog
);

    localparam logic [W-1:0] INIT_NUM_W = W'(INIT_NUM);
    localparam logic [W-1:0] INIT_DEN_W = W'(INIT_DEN);

    // Per-channel configuration, exposed for the readback mux.
    logic [W-1:0] num_arr [NCH];
    logic [W-1:0] den_arr [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] num_reg, num_next;
            logic [W-1:0] den_reg, den_next;
            logic [W-1:0] acc_reg, acc_next;
            logic         ce_reg,  ce_next;
            logic         tog_reg, tog_next;
            logic [W:0]   sum;
            logic         wr_hit;

            // An out-of-range wr_ch simply matches no channel.
            assign wr_hit = wr && (wr_ch == 3'(gi));

            always_comb begin
                // One extra bit so acc + num can never wrap.
                sum      = {1'b0, acc_reg} + {1'b0, num_reg};
                num_next = num_reg;
                den_next = den_reg;
                acc_next = acc_reg;
                ce_next  = 1'b0;
                tog_next = tog_reg;

                if (resync) begin
                    acc_next = '0;
                end else if (pause) begin
                    // hold everything, ce stays low
                end else if (den_reg == '0) begin
                    // disabled channel
                    acc_next = '0;
                end else if (num_reg >= den_reg) begin
                    // ratio >= 1: fire every cycle with a pinned accumulator
                    ce_next  = 1'b1;
                    acc_next = '0;
                    tog_next = ~tog_reg;
                end else if (sum >= {1'b0, den_reg}) begin
                    ce_next  = 1'b1;
                    acc_next = W'(sum - {1'b0, den_reg});
                    tog_next = ~tog_reg;
                end else begin
                    acc_next = sum[W-1:0];
                end

                // ce/tog above were decided with the old ratio; the write only
                // replaces the configuration and restarts the phase.
                if (wr_hit) begin
                    num_next = wr_num;
                    den_next = wr_den;
                    acc_next = '0;
                end
            end

            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    num_reg <= INIT_NUM_W;
                    den_reg <= INIT_DEN_W;
                    acc_reg <= '0;
                    ce_reg  <= 1'b0;
                    tog_reg <= 1'b0;
                end else begin
                    num_reg <= num_next;
                    den_reg <= den_next;
                    acc_reg <= acc_next;
                    ce_reg  <= ce_next;
                    tog_reg <= tog_next;
                end
            end

            assign ce[gi]      = ce_reg;
            assign tog[gi]     = tog_reg;
            assign num_arr[gi] = num_reg;
            assign den_arr[gi] = den_reg;
        end
    endgenerate

    always_comb begin
        rd_num = '0;
        rd_den = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == 3'(i)) begin
                rd_num = num_arr[i];
                rd_den = den_arr[i];
            end
        end
    end

endmodule
